// File: rtl/maxnet_core_n.sv
// Parametrised N-channel Maxnet winner-take-all engine on signed fixed-point lanes.
// Optional MAXNET_TIE_BREAK_EN keeps the pre-update vector to resolve a simultaneous collapse to zero.
module maxnet_core_n #(
  parameter int N        = 4,
  parameter int DATA_W   = 32,
  parameter int FRAC_W   = 16,
  parameter int MAX_ITER = 64,
  localparam int IDX_W   = $clog2(N),
  localparam int ITER_W  = $clog2(MAX_ITER + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N*DATA_W-1:0]   x_in,
  input  logic [DATA_W-1:0]     w_self,
  input  logic [DATA_W-1:0]     w_inh,
  output logic                  busy,
  output logic                  done,
  output logic                  winner_valid,
  output logic [IDX_W-1:0]      winner_idx,
  output logic [DATA_W-1:0]     max_val,
  output logic                  timeout,
  output logic [ITER_W-1:0]     iter_cnt
);

  localparam int SW  = DATA_W + IDX_W;
  localparam int PSW = 2 * DATA_W;
  localparam int PIW = DATA_W + SW;
  localparam int PW  = PIW + 1;
  localparam logic [IDX_W:0]         NZ_ONE   = (IDX_W + 1)'(1);
  localparam logic [ITER_W-1:0]      ITER_MAX = ITER_W'(MAX_ITER);
  localparam logic signed [DATA_W-1:0] MAXPOS = {1'b0, {(DATA_W - 1){1'b1}}};

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t state_q, state_d;

  logic signed [DATA_W-1:0] act_q  [N];
  logic signed [DATA_W-1:0] orig_q [N];
  logic signed [DATA_W-1:0] act_d  [N];
  logic signed [DATA_W-1:0] xClamp [N];
  logic signed [DATA_W-1:0] wSelf_q, wInh_q;
  logic [ITER_W-1:0]        iterCnt_q;
  logic                     winnerValid_q, timeout_q;
  logic [IDX_W-1:0]         winnerIdx_q, loneIdx;
  logic [DATA_W-1:0]        maxVal_q;
  logic [IDX_W:0]           nz;
  logic signed [SW-1:0]     sumAct;
  logic                     finish, update;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      xClamp[i] = x_in[i*DATA_W + DATA_W - 1] ? '0 : $signed(x_in[i*DATA_W +: DATA_W]);
    end
  end

  always_comb begin
    nz      = '0;
    loneIdx = '0;
    sumAct  = '0;
    for (int i = 0; i < N; i++) begin
      sumAct = sumAct + SW'(act_q[i]);
      if (act_q[i] != '0) begin
        nz      = nz + NZ_ONE;
        loneIdx = IDX_W'(i);
      end
    end
  end

  // Each lane: self term plus inhibition from all other lanes, summed wide then relu/saturated.
  always_comb begin : lane_update
    logic signed [SW-1:0]  diff;
    logic signed [PSW-1:0] pSelf;
    logic signed [PIW-1:0] pInh;
    logic signed [PW-1:0]  tSum;
    for (int i = 0; i < N; i++) begin
      diff  = sumAct - SW'(act_q[i]);
      pSelf = PSW'(wSelf_q) * PSW'(act_q[i]);
      pInh  = PIW'(wInh_q) * PIW'(diff);
      tSum  = (PW'(pSelf) >>> FRAC_W) + (PW'(pInh) >>> FRAC_W);
      if (tSum < 0) begin
        act_d[i] = '0;
      end else if (tSum > PW'(MAXPOS)) begin
        act_d[i] = MAXPOS;
      end else begin
        act_d[i] = tSum[DATA_W-1:0];
      end
    end
  end

  assign finish = (nz <= NZ_ONE) || (iterCnt_q == ITER_MAX);
  assign update = (state_q == ITER) && !finish;

`ifdef MAXNET_TIE_BREAK_EN
  logic signed [DATA_W-1:0] prev_q [N];
  logic [IDX_W-1:0]         tieIdx;

  always_comb begin : tie_pick
    logic signed [DATA_W-1:0] best;
    best   = prev_q[0];
    tieIdx = '0;
    for (int i = 1; i < N; i++) begin
      if (prev_q[i] > best) begin
        best   = prev_q[i];
        tieIdx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) prev_q[i] <= '0;
    end else if (update) begin
      for (int i = 0; i < N; i++) prev_q[i] <= act_q[i];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ITER;
      ITER:    if (finish) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        act_q[i]  <= '0;
        orig_q[i] <= '0;
      end
      wSelf_q       <= '0;
      wInh_q        <= '0;
      iterCnt_q     <= '0;
      winnerValid_q <= 1'b0;
      winnerIdx_q   <= '0;
      maxVal_q      <= '0;
      timeout_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          for (int i = 0; i < N; i++) begin
            act_q[i]  <= xClamp[i];
            orig_q[i] <= xClamp[i];
          end
          wSelf_q       <= w_self;
          wInh_q        <= w_inh;
          iterCnt_q     <= '0;
          winnerValid_q <= 1'b0;
          winnerIdx_q   <= '0;
          maxVal_q      <= '0;
          timeout_q     <= 1'b0;
        end
        ITER: begin
          if (nz == NZ_ONE) begin
            winnerValid_q <= 1'b1;
            winnerIdx_q   <= loneIdx;
            maxVal_q      <= orig_q[loneIdx];
          end else if (nz > NZ_ONE) begin
            if (iterCnt_q == ITER_MAX) begin
              timeout_q <= 1'b1;
            end else begin
              for (int i = 0; i < N; i++) act_q[i] <= act_d[i];
              iterCnt_q <= iterCnt_q + ITER_W'(1);
            end
          end
`ifdef MAXNET_TIE_BREAK_EN
          else if (iterCnt_q != '0) begin
            winnerValid_q <= 1'b1;
            winnerIdx_q   <= tieIdx;
            maxVal_q      <= orig_q[tieIdx];
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy         = (state_q == ITER);
  assign done         = (state_q == DONE);
  assign winner_valid = winnerValid_q;
  assign winner_idx   = winnerIdx_q;
  assign max_val      = maxVal_q;
  assign timeout      = timeout_q;
  assign iter_cnt     = iterCnt_q;

endmodule

// File: tb/tb_maxnet_core_n.sv
// Self-checking bench for maxnet_core_n: one default instance and one with MAX_ITER=4.
// Expected results come from a behavioural Maxnet model and are scoreboarded per run.
module tb_maxnet_core_n;

  localparam int WSELF = 65536;
  localparam int WEPS  = -13107;
  localparam int WHALF = -32768;
`ifdef MAXNET_TIE_BREAK_EN
  localparam bit TIE_EN = 1'b1;
`else
  localparam bit TIE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, startMain, startShort;
  logic [127:0] xIn;
  logic [31:0]  wSelf, wInh;

  logic        busyMain, doneMain, validMain, toutMain;
  logic [1:0]  idxMain;
  logic [31:0] maxMain;
  logic [6:0]  iterMain;
  logic        busyShort, doneShort, validShort, toutShort;
  logic [1:0]  idxShort;
  logic [31:0] maxShort;
  logic [2:0]  iterShort;

  typedef struct {
    logic        valid;
    logic [1:0]  idx;
    logic [31:0] maxv;
    logic        tout;
    logic [6:0]  iter;
  } expect_t;

  expect_t sbQ[$];
  int compareCnt  = 0;
  int mismatchCnt = 0;
  int vec[4];
  int sawDone;

  always #5 clk = ~clk;

  maxnet_core_n #(.N(4), .DATA_W(32), .FRAC_W(16), .MAX_ITER(64)) dutMain (
    .clk(clk), .rst(rst), .start(startMain), .x_in(xIn), .w_self(wSelf), .w_inh(wInh),
    .busy(busyMain), .done(doneMain), .winner_valid(validMain), .winner_idx(idxMain),
    .max_val(maxMain), .timeout(toutMain), .iter_cnt(iterMain)
  );

  maxnet_core_n #(.N(4), .DATA_W(32), .FRAC_W(16), .MAX_ITER(4)) dutShort (
    .clk(clk), .rst(rst), .start(startShort), .x_in(xIn), .w_self(wSelf), .w_inh(wInh),
    .busy(busyShort), .done(doneShort), .winner_valid(validShort), .winner_idx(idxShort),
    .max_val(maxShort), .timeout(toutShort), .iter_cnt(iterShort)
  );

  // Behavioural Maxnet run: clamp, iterate until at most one lane survives or the cap is hit.
  function automatic expect_t modelRun(input int xs[4], input int ws, input int wi, input int maxIt);
    expect_t e;
    longint a[4], o[4], p[4], s, nxt, best;
    int nz, it, last;
    e = '{valid: 1'b0, idx: 2'd0, maxv: 32'd0, tout: 1'b0, iter: 7'd0};
    for (int i = 0; i < 4; i++) begin
      a[i] = (xs[i] < 0) ? 64'sd0 : longint'(xs[i]);
      o[i] = a[i];
      p[i] = 0;
    end
    it = 0;
    nz = 0;
    last = 0;
    while (1'b1) begin
      nz = 0;
      for (int i = 0; i < 4; i++) if (a[i] != 0) begin nz++; last = i; end
      if (nz <= 1) break;
      if (it == maxIt) begin e.tout = 1'b1; break; end
      s = a[0] + a[1] + a[2] + a[3];
      for (int i = 0; i < 4; i++) p[i] = a[i];
      for (int i = 0; i < 4; i++) begin
        nxt = ((longint'(ws) * p[i]) >>> 16) + ((longint'(wi) * (s - p[i])) >>> 16);
        if (nxt < 0) nxt = 0;
        if (nxt > 64'sd2147483647) nxt = 64'sd2147483647;
        a[i] = nxt;
      end
      it++;
    end
    e.iter = it[6:0];
    if (!e.tout) begin
      if (nz == 1) begin
        e.valid = 1'b1;
        e.idx   = last[1:0];
        e.maxv  = o[last][31:0];
      end else if (TIE_EN && it > 0) begin
        best = p[0];
        last = 0;
        for (int i = 1; i < 4; i++) if (p[i] > best) begin best = p[i]; last = i; end
        e.valid = 1'b1;
        e.idx   = last[1:0];
        e.maxv  = o[last][31:0];
      end
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compareCnt++;
    assert (obs === exp) else begin
      mismatchCnt++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One run: drive, scoreboard the model result, wait (bounded) for done, compare at the done cycle.
  task automatic applyStimulus(input string tag, input int xs[4], input int ws, input int wi,
                               input bit useShort, input bit poke);
    expect_t e, got;
    int cyc;
    @(negedge clk);
    for (int i = 0; i < 4; i++) xIn[i*32 +: 32] = xs[i];
    wSelf = ws;
    wInh  = wi;
    e = modelRun(xs, ws, wi, useShort ? 4 : 64);
    sbQ.push_back(e);
    if (useShort) startShort = 1'b1;
    else          startMain  = 1'b1;
    @(negedge clk);
    startMain  = 1'b0;
    startShort = 1'b0;
    checkOutput({tag, ".busy"}, useShort ? busyShort : busyMain, 1);
    if (poke) begin
      xIn   = {32'd0, 32'h00008000, 32'd0, 32'd0};
      startMain = 1'b1;
    end
    cyc = 0;
    while (!(useShort ? doneShort : doneMain) && cyc < 200) begin
      @(negedge clk);
      startMain = 1'b0;
      cyc++;
    end
    startMain = 1'b0;
    got = sbQ.pop_front();
    checkOutput({tag, ".latency"}, cyc, 64'(got.iter) + 1);
    checkOutput({tag, ".valid"}, useShort ? validShort : validMain, got.valid);
    checkOutput({tag, ".idx"},   useShort ? idxShort : idxMain, got.idx);
    checkOutput({tag, ".max"},   useShort ? maxShort : maxMain, got.maxv);
    checkOutput({tag, ".tout"},  useShort ? toutShort : toutMain, got.tout);
    checkOutput({tag, ".iter"},  useShort ? 7'(iterShort) : iterMain, got.iter);
    if (poke) startMain = 1'b1;
    @(negedge clk);
    startMain = 1'b0;
    checkOutput({tag, ".donePulse"}, useShort ? doneShort : doneMain, 0);
    checkOutput({tag, ".idleBusy"},  useShort ? busyShort : busyMain, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; startMain = 1'b0; startShort = 1'b0;
    xIn = '0; wSelf = '0; wInh = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst.busy",  busyMain, 0);
    checkOutput("rst.done",  doneMain, 0);
    checkOutput("rst.valid", validMain, 0);
    checkOutput("rst.idx",   idxMain, 0);
    checkOutput("rst.max",   maxMain, 0);
    checkOutput("rst.tout",  toutMain, 0);
    checkOutput("rst.iter",  iterMain, 0);
    checkOutput("rst.shortBusy", busyShort, 0);
    rst = 1'b0;

    $display("[TB] test 1: graded inputs");
    vec = '{13107, 26214, 39322, 52429};
    applyStimulus("t1", vec, WSELF, WEPS, 1'b0, 1'b0);
    checkOutput("t1.constIdx", idxMain, 3);
    checkOutput("t1.constMax", maxMain, 32'h0000CCCD);

    $display("[TB] test 2: single nonzero lane");
    vec = '{0, 0, 32768, 0};
    applyStimulus("t2", vec, WSELF, WEPS, 1'b0, 1'b0);
    checkOutput("t2.constIter", iterMain, 0);
    checkOutput("t2.constIdx",  idxMain, 2);
    checkOutput("t2.constMax",  maxMain, 32'h00008000);

    $display("[TB] test 3: all lanes clamp to zero");
    vec = '{-65536, 0, -32768, 0};
    applyStimulus("t3", vec, WSELF, WEPS, 1'b0, 1'b0);
    checkOutput("t3.constValid", validMain, 0);
    checkOutput("t3.constMax",   maxMain, 0);

    $display("[TB] test 4: equal lanes collapse together");
    vec = '{32768, 32768, 0, 0};
    applyStimulus("t4", vec, WSELF, WHALF, 1'b0, 1'b0);
    checkOutput("t4.constValid", validMain, TIE_EN);
    checkOutput("t4.constIdx",   idxMain, 0);
    checkOutput("t4.constIter",  iterMain, 16);

    $display("[TB] test 5: iteration cap");
    applyStimulus("t5", vec, WSELF, WHALF, 1'b1, 1'b0);
    checkOutput("t5.constTout",  toutShort, 1);
    checkOutput("t5.constIter",  iterShort, 4);
    checkOutput("t5.constValid", validShort, 0);

    $display("[TB] test 7: start ignored while busy and in done");
    vec = '{13107, 26214, 39322, 52429};
    applyStimulus("t7", vec, WSELF, WEPS, 1'b0, 1'b1);
    checkOutput("t7.constIdx", idxMain, 3);

    $display("[TB] test 6: reset mid-run");
    @(negedge clk);
    xIn = {32'd52429, 32'd39322, 32'd26214, 32'd13107};
    wSelf = WSELF; wInh = WEPS;
    startMain = 1'b1;
    @(negedge clk);
    startMain = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("t6.midBusy", busyMain, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t6.busy",  busyMain, 0);
    checkOutput("t6.done",  doneMain, 0);
    checkOutput("t6.valid", validMain, 0);
    checkOutput("t6.idx",   idxMain, 0);
    checkOutput("t6.max",   maxMain, 0);
    checkOutput("t6.tout",  toutMain, 0);
    checkOutput("t6.iter",  iterMain, 0);
    rst = 1'b0;
    sawDone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (doneMain) sawDone++;
    end
    checkOutput("t6.noDone", sawDone, 0);

    checkOutput("sb.empty", sbQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, mismatchCnt);
    $finish;
  end

endmodule
